// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch unit for the RV32 core. It holds the PC and issues word
// reads to instruction memory over a ready handshake. It registers the returned
// word and presents it to decode with the control key {funct7, funct3, opcode}
// already extracted and a 3-bit instruction-type code. Branch/jump redirects
// reload the PC. A misaligned redirect target parks the unit in a sticky fault
// state that only reset clears.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word-aligned)
//
// Ports:
//   clk          system clock, rising-edge
//   nRst         asynchronous active-low reset
//   imem_read    read request to instruction memory
//   imem_addr    request address (the PC register)
//   imem_data    read data, valid with imem_ready
//   imem_ready   memory completes the current request this cycle
//   stall        decode cannot accept; hold the presented instruction
//   redirect_en  load redirect_pc (branch taken / jump)
//   redirect_pc  redirect target
//   instruction  registered instruction word
//   inst_pc      address the instruction was fetched from
//   inst_valid   instruction / inst_pc / decode_key / i_type are valid
//   decode_key   {instruction[31:25], instruction[14:12], instruction[6:0]}
//   i_type       instruction-type code (R=0 I=1 S=2 SB=3 UJ=4 U=5 illegal=7)
//   fault        sticky misaligned-redirect fault
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [16:0] decode_key,
  output logic [2:0]  i_type,
  output logic        fault
);

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam logic [2:0]  TYPE_R    = 3'd0;
  localparam logic [2:0]  TYPE_I    = 3'd1;
  localparam logic [2:0]  TYPE_S    = 3'd2;
  localparam logic [2:0]  TYPE_SB   = 3'd3;
  localparam logic [2:0]  TYPE_UJ   = 3'd4;
  localparam logic [2:0]  TYPE_U    = 3'd5;
  localparam logic [2:0]  TYPE_ILL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Map the 7-bit opcode onto the type code the control unit expects.
  // Unknown opcodes still produce a valid instruction; decode traps them.
  function automatic logic [2:0] decode_type(input logic [6:0] opc);
    logic [2:0] t;
    case (opc)
      7'b0110011:                         t = TYPE_R;
      7'b0010011, 7'b0000011, 7'b1100111: t = TYPE_I;
      7'b0100011:                         t = TYPE_S;
      7'b1100011:                         t = TYPE_SB;
      7'b1101111:                         t = TYPE_UJ;
      7'b0110111, 7'b0010111:             t = TYPE_U;
      default:                            t = TYPE_ILL;
    endcase
    return t;
  endfunction

  // A redirect target must sit on a word boundary.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  state_t      state;
  logic [31:0] pc_p0;
  logic        read_p0;
  logic [31:0] inst_p1;
  logic [31:0] inst_pc_p1;
  logic [2:0]  i_type_p1;
  logic        vld_p1;
  logic        fault_p1;

  // ---- request stage (p0) / registered instruction stage (p1) ----
  // Every output is a register. Redirect outranks both imem_ready and stall,
  // so a word that returns in the same cycle as a redirect is dropped.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      pc_p0      <= RESET_PC;
      read_p0    <= 1'b0;
      inst_p1    <= NOP_INST;
      inst_pc_p1 <= 32'h0000_0000;
      i_type_p1  <= TYPE_I;
      vld_p1     <= 1'b0;
      fault_p1   <= 1'b0;
    end else if (state == FAULT) begin
      // Parked until reset; keep the bus quiet and the fault flag up.
      read_p0  <= 1'b0;
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b1;
    end else if (redirect_en) begin
      if (is_aligned(redirect_pc)) begin
        pc_p0   <= redirect_pc;
        read_p0 <= 1'b1;
        vld_p1  <= 1'b0;
        state   <= REQ;
      end else begin
        // The PC keeps its old value so the faulting context is still visible.
        read_p0  <= 1'b0;
        vld_p1   <= 1'b0;
        fault_p1 <= 1'b1;
        state    <= FAULT;
      end
    end else begin
      case (state)
        IDLE: begin
          // One quiet cycle after reset before the first request.
          read_p0 <= 1'b1;
          state   <= REQ;
        end
        REQ: begin
          if (imem_ready) begin
            inst_p1    <= imem_data;
            inst_pc_p1 <= pc_p0;
            i_type_p1  <= decode_type(imem_data[6:0]);
            pc_p0      <= pc_p0 + PC_STEP;  // 32-bit wrap is intended
            vld_p1     <= 1'b1;
            read_p0    <= 1'b0;
            state      <= VALID;
          end
        end
        VALID: begin
          // Consumed when decode accepts; the next fetch starts right away.
          if (!stall) begin
            vld_p1  <= 1'b0;
            read_p0 <= 1'b1;
            state   <= REQ;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  assign imem_read   = read_p0;
  assign imem_addr   = pc_p0;
  assign instruction = inst_p1;
  assign inst_pc     = inst_pc_p1;
  assign inst_valid  = vld_p1;
  assign i_type      = i_type_p1;
  assign fault       = fault_p1;
  assign decode_key  = {inst_p1[31:25], inst_p1[14:12], inst_p1[6:0]};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADD    = 32'h00B5_0533;
  localparam logic [31:0] JAL    = 32'h0000_006F;
  localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

  logic        clk;
  logic        nRst;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [16:0] decode_key;
  logic [2:0]  i_type;
  logic        fault;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .imem_read   (imem_read),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .decode_key  (decode_key),
    .i_type      (i_type),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] data;
    logic        stl;
    logic        redir;
    logic [31:0] rpc;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [16:0] e_key;
    logic [2:0]  e_ity;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic [31:0] data, input logic stl,
                              input logic redir, input logic [31:0] rpc,
                              input logic e_read, input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc,
                              input logic [16:0] e_key, input logic [2:0] e_ity,
                              input logic e_fault);
    vec_t v;
    v.rdy = rdy; v.data = data; v.stl = stl; v.redir = redir; v.rpc = rpc;
    v.e_read = e_read; v.e_addr = e_addr; v.e_vld = e_vld; v.e_inst = e_inst;
    v.e_ipc = e_ipc; v.e_key = e_key; v.e_ity = e_ity; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_read, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_inst, input logic [31:0] e_ipc,
                         input logic [16:0] e_key, input logic [2:0] e_ity, input logic e_fault);
    chk({tag, ".imem_read"},   {31'd0, imem_read},  {31'd0, e_read});
    chk({tag, ".imem_addr"},   imem_addr,           e_addr);
    chk({tag, ".inst_valid"},  {31'd0, inst_valid}, {31'd0, e_vld});
    chk({tag, ".instruction"}, instruction,         e_inst);
    chk({tag, ".inst_pc"},     inst_pc,             e_ipc);
    chk({tag, ".decode_key"},  {15'd0, decode_key}, {15'd0, e_key});
    chk({tag, ".i_type"},      {29'd0, i_type},     {29'd0, e_ity});
    chk({tag, ".fault"},       {31'd0, fault},      {31'd0, e_fault});
  endtask

  // ---------------- reference model ----------------
  // The unit is described by three facts: whether it has left the startup
  // cycle, whether it holds an instruction for decode, and whether it has
  // faulted. It is requesting whenever it has started and is neither holding
  // nor faulted.
  int unsigned type_map [bit [6:0]];
  bit          m_started, m_holding, m_faulted;
  logic [31:0] m_pc, m_inst, m_ipc;

  function automatic logic [2:0] ref_type(input logic [6:0] opc);
    if (type_map.exists(opc)) return type_map[opc][2:0];
    return 3'd7;
  endfunction

  task automatic model_reset();
    m_started = 0; m_holding = 0; m_faulted = 0;
    m_pc = RST_PC; m_inst = NOP; m_ipc = 32'h0;
  endtask

  task automatic model_step(input logic rdy, input logic [31:0] data, input logic stl,
                            input logic redir, input logic [31:0] rpc);
    if (m_faulted) begin
    end else if (redir) begin
      if (rpc % 4 != 0) m_faulted = 1;
      else begin m_pc = rpc; m_holding = 0; m_started = 1; end
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_holding) begin
      if (!stl) m_holding = 0;
    end else if (rdy) begin
      m_inst = data; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_holding = 1;
    end
  endtask

  task automatic model_check(input string tag);
    chk_all(tag, m_started && !m_faulted && !m_holding, m_pc, m_holding && !m_faulted,
            m_inst, m_ipc, {m_inst[31:25], m_inst[14:12], m_inst[6:0]},
            ref_type(m_inst[6:0]), m_faulted);
  endtask

  logic [6:0] opcodes [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                               7'h6F, 7'h37, 7'h17, 7'h7F};

  initial begin
    type_map[7'b0110011] = 0;
    type_map[7'b0010011] = 1; type_map[7'b0000011] = 1; type_map[7'b1100111] = 1;
    type_map[7'b0100011] = 2;
    type_map[7'b1100011] = 3;
    type_map[7'b1101111] = 4;
    type_map[7'b0110111] = 5; type_map[7'b0010111] = 5;

    nRst = 1'b0; imem_ready = 1'b0; imem_data = 32'h0; stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0;

    // Reset held for three cycles; outputs at reset values throughout.
    repeat (3) begin
      @(negedge clk); #1;
      chk_all("reset", 0, RST_PC, 0, NOP, 32'h0, 17'h00013, 3'd1, 0);
    end

    // Directed table: startup, basic fetch, stall hold, redirect collision,
    // wrap with jal, illegal type, misaligned redirect with sticky fault.
    vecs.push_back(mk(0, 0, 0, 0, 0,              0, 0, 0, NOP, 0, 17'h00013, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,              1, 0, 0, NOP, 0, 17'h00013, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,              1, 0, 0, NOP, 0, 17'h00013, 1, 0));
    vecs.push_back(mk(1, ADD, 0, 0, 0,            1, 0, 0, NOP, 0, 17'h00013, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0,            0, 4, 1, ADD, 0, 17'h00033, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,              0, 4, 1, ADD, 0, 17'h00033, 0, 0));
    vecs.push_back(mk(1, 32'hDEADBEEF, 0, 1, 32'h100,
                                                  1, 4, 0, ADD, 0, 17'h00033, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC,  1, 32'h100, 0, ADD, 0, 17'h00033, 0, 0));
    vecs.push_back(mk(1, JAL, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, ADD, 0, 17'h00033, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,              0, 0, 1, JAL, 32'hFFFF_FFFC, 17'h0006F, 4, 0));
    vecs.push_back(mk(1, ONES, 0, 0, 0,           1, 0, 0, JAL, 32'hFFFF_FFFC, 17'h0006F, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,              0, 4, 1, ONES, 0, 17'h1FFFF, 7, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h102,        1, 4, 0, ONES, 0, 17'h1FFFF, 7, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, NOP, 0, 1, 32'h200,    0, 4, 0, ONES, 0, 17'h1FFFF, 7, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      nRst = 1'b1;
      imem_ready = vecs[i].rdy; imem_data = vecs[i].data; stall = vecs[i].stl;
      redirect_en = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr, vecs[i].e_vld,
              vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_key, vecs[i].e_ity, vecs[i].e_fault);
    end

    // Reset clears the sticky fault immediately.
    @(negedge clk);
    nRst = 1'b0; imem_ready = 1'b0; redirect_en = 1'b0; #1;
    chk_all("fault_clear", 0, RST_PC, 0, NOP, 32'h0, 17'h00013, 3'd1, 0);

    // Redirect from the startup cycle, then reset in the middle of the request.
    @(negedge clk);
    nRst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_en = 1'b0; #1;
    chk_all("idle_redirect", 1, 32'h40, 0, NOP, 32'h0, 17'h00013, 3'd1, 0);
    @(posedge clk); #3;
    nRst = 1'b0; #1;
    chk_all("async_reset", 0, RST_PC, 0, NOP, 32'h0, 17'h00013, 3'd1, 0);

    // Randomized run against the model.
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        r_rst, r_rdy, r_stl, r_redir;
      logic [31:0] r_data, r_rpc;
      @(negedge clk);
      r_rst   = (cyc == 0) || ($urandom_range(0, 99) == 0) || (m_faulted && $urandom_range(0, 7) == 0);
      r_rdy   = ($urandom_range(0, 2) != 0);
      r_stl   = ($urandom_range(0, 2) == 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_rpc   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) r_rpc = 32'hFFFF_FFF8 | ($urandom & 32'h4);
      if ($urandom_range(0, 9) == 0) r_rpc = r_rpc | 32'($urandom_range(1, 3));
      r_data  = {$urandom} & 32'hFFFF_FF80;
      r_data  = r_data | 32'(opcodes[$urandom_range(0, 9)]);
      nRst = !r_rst; imem_ready = r_rdy; imem_data = r_data; stall = r_stl;
      redirect_en = r_redir; redirect_pc = r_rpc;
      if (r_rst) model_reset();
      #1;
      model_check($sformatf("rnd%0d", cyc));
      @(posedge clk);
      if (!r_rst) model_step(r_rdy, r_data, r_stl, r_redir, r_rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the RV32 core. It holds the PC, issues word reads to instruction memory over a ready handshake, and registers the returned instruction. It presents that instruction to the decode stage together with its pre-extracted 17-bit control key {funct7, funct3, opcode} and its 3-bit instruction-type code, the exact inputs the control logic unit consumes. It also accepts branch/jump redirects and traps misaligned targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- imem_read  out  1  read request to instruction memory.
- imem_addr  out  32  word address of request; equals internal PC register.
- imem_data  in  32  read data; valid when imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- stall  in  1  decode cannot accept; holds presented instruction.
- redirect_en  in  1  branch taken / jump; load redirect_pc.
- redirect_pc  in  32  redirect target.
- instruction  out  32  registered instruction word.
- inst_pc  out  32  address instruction was fetched from.
- inst_valid  out  1  instruction/inst_pc/decode_key/i_type valid.
- decode_key  out  17  {instruction[31:25], instruction[14:12], instruction[6:0]}.
- i_type  out  3  type code of instruction (see Operation).
- fault  out  1  sticky misaligned-redirect fault.

## Operation
- FSM states: IDLE, REQ, VALID, FAULT.
- IDLE: entered on reset; unconditionally -> REQ next cycle.
- REQ: imem_read=1, imem_addr=pc held stable until imem_ready. On imem_ready=1: instruction<=imem_data, inst_pc<=pc, pc<=pc+4, inst_valid<=1, -> VALID.
- VALID: imem_read=0; outputs held. Instruction is consumed on any cycle with inst_valid=1 and stall=0; the FSM then goes -> REQ and inst_valid<=0.
- FAULT: imem_read=0, inst_valid=0, fault=1; exits only by reset.
- Redirect (any of IDLE/REQ/VALID), highest priority over imem_ready and stall: if redirect_pc[1:0]==0, pc<=redirect_pc, inst_valid<=0, -> REQ. The in-flight request is abandoned, and data returned in the same cycle is discarded. If redirect_pc[1:0]!=0: -> FAULT, pc unchanged.
- PC arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no fault.
- i_type is registered with instruction and decoded from opcode [6:0]:
  - 0110011 -> 0 (R).
  - 0010011, 0000011, 1100111 -> 1 (I).
  - 0100011 -> 2 (S).
  - 1100011 -> 3 (SB).
  - 1101111 -> 4 (UJ).
  - 0110111, 0010111 -> 5 (U).
  - Anything else -> 7 (illegal). inst_valid is still asserted; decode handles illegal instructions.
- decode_key is combinational from the instruction register.

## Timing
- Reset values:
  - pc=imem_addr=RESET_PC.
  - imem_read=0, inst_valid=0, fault=0.
  - instruction=32'h0000_0013 (NOP), so decode_key=17'h00013 and i_type=1.
  - inst_pc=0, state IDLE.
- First request: imem_read=1 on the first cycle after nRst deasserts, not the IDLE cycle.
- Fetch latency: imem_ready sampled high at edge k -> inst_valid=1 during cycle k+1.
- Back-to-back: instruction consumed at edge m -> imem_read=1 at cycle m+1 with addr=previous+4. Peak rate is one instruction per 2 cycles with zero-wait memory.
- stall=1 in VALID: all outputs frozen indefinitely; no memory request is issued.
- Redirect sampled at edge r -> cycle r+1: imem_addr=redirect_pc, imem_read=1, inst_valid=0.
- Asynchronous reset mid-request: outputs return to reset values immediately; the outstanding request is dropped.

## Test plan
- Reset/startup: hold nRst low 3 cycles, release. All outputs are at reset values. Cycle +1: imem_read=1, imem_addr=0.
- Basic fetch: imem_ready after 2 wait cycles with data 32'h00B50533 (add). Required: inst_valid=1, instruction=32'h00B50533, inst_pc=0, decode_key=17'h00033, i_type=0. Next request is at addr 4.
- Stall hold: stall=1 for 5 cycles in VALID. Outputs are stable and imem_read=0. Release stall: next cycle imem_read=1 at addr+4.
- Redirect mid-request: redirect_en=1 with redirect_pc=32'h0000_0100 in the same cycle as imem_ready (data 32'hDEADBEEF). Data is discarded, inst_valid stays 0, and the next request is at 0x100.
- Misaligned redirect: redirect_pc=32'h0000_0102. fault=1 and imem_read=0 permanently; only nRst clears it.
- Wrap and type decode: redirect to 32'hFFFF_FFFC and return 32'h0000006F (jal). Required: i_type=4, inst_pc=32'hFFFF_FFFC, next imem_addr=0. Return 32'hFFFFFFFF -> i_type=7.
